// File: rtl/tmds_encoder_8b10b.sv
// TMDS channel encoder: 8b video / 2b control -> 10b symbol, 2-stage pipeline.
// Define TMDS_TERC4_EN to emit TERC4 data-island symbols when de=0 and island=1.
module tmds_encoder_8b10b #(
  parameter bit INV_OUT = 1'b0
) (
  input  logic       pclk,
  input  logic       txrst,
  input  logic       de,
  input  logic [1:0] c,
  input  logic [7:0] din,
  input  logic       island,
  input  logic [3:0] aux,
  output logic [9:0] tmds_q,
  output logic [4:0] disparity
);

  localparam logic [9:0] TOK0 = 10'h354;
  localparam logic [9:0] TOK1 = 10'h0AB;
  localparam logic [9:0] TOK2 = 10'h154;
  localparam logic [9:0] TOK3 = 10'h2AB;

  logic [3:0] n1d;
  logic       xnor_m;
  logic [8:0] qm_d, qm_q;
  logic       de1_d, de1_q;
  logic [1:0] c1_d, c1_q;

`ifdef TMDS_TERC4_EN
  logic       isl1_d, isl1_q;
  logic [3:0] aux1_d, aux1_q;

  function automatic logic [9:0] terc4(input logic [3:0] n);
    logic [9:0] s;
    unique case (n)
      4'h0: s = 10'h29C;
      4'h1: s = 10'h263;
      4'h2: s = 10'h2E4;
      4'h3: s = 10'h2E2;
      4'h4: s = 10'h171;
      4'h5: s = 10'h11E;
      4'h6: s = 10'h18E;
      4'h7: s = 10'h13C;
      4'h8: s = 10'h2CC;
      4'h9: s = 10'h139;
      4'hA: s = 10'h19C;
      4'hB: s = 10'h2C6;
      4'hC: s = 10'h28E;
      4'hD: s = 10'h271;
      4'hE: s = 10'h163;
      default: s = 10'h2C3;
    endcase
    return s;
  endfunction
`else
  logic unused_ok;
  assign unused_ok = ^{island, aux};
`endif

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b0, din[i]};
    xnor_m = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);
    qm_d = '0;
    qm_d[0] = din[0];
    for (int i = 1; i < 8; i++) qm_d[i] = qm_d[i-1] ^ din[i] ^ xnor_m;
    qm_d[8] = ~xnor_m;
    de1_d = de;
    c1_d = c;
`ifdef TMDS_TERC4_EN
    isl1_d = island;
    aux1_d = aux;
`endif
  end

  logic [3:0] n1q;
  logic [4:0] diff;
  logic [4:0] cnt_d, cnt_q;
  logic [4:0] bon2, nbon2;
  logic       case_a, case_b;
  logic [9:0] sym_d, tmds_d;

  // diff = n1q - n0q = 2*n1q - 8, two's complement
  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b0, qm_q[i]};
    diff = {n1q, 1'b0} - 5'd8;
    case_a = (cnt_q == 5'd0) || (diff == 5'd0);
    case_b = !case_a && (cnt_q[4] == diff[4]);
    bon2 = {3'b0, qm_q[8], 1'b0};
    nbon2 = {3'b0, ~qm_q[8], 1'b0};
    sym_d = TOK0;
    cnt_d = cnt_q;
    if (!de1_q) begin
      cnt_d = '0;
      unique case (c1_q)
        2'b00: sym_d = TOK0;
        2'b01: sym_d = TOK1;
        2'b10: sym_d = TOK2;
        2'b11: sym_d = TOK3;
      endcase
`ifdef TMDS_TERC4_EN
      if (isl1_q) sym_d = terc4(aux1_q);
`endif
    end else begin
      unique case (1'b1)
        case_a: begin
          sym_d = {~qm_q[8], qm_q[8],
                   qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d = qm_q[8] ? cnt_q + diff : cnt_q - diff;
        end
        case_b: begin
          sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d = cnt_q + bon2 - diff;
        end
        default: begin
          sym_d = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d = cnt_q + diff - nbon2;
        end
      endcase
    end
    tmds_d = INV_OUT ? ~sym_d : sym_d;
  end

  always_ff @(posedge pclk) begin
    if (txrst) begin
      qm_q   <= '0;
      de1_q  <= 1'b0;
      c1_q   <= 2'b00;
`ifdef TMDS_TERC4_EN
      isl1_q <= 1'b0;
      aux1_q <= 4'h0;
`endif
      cnt_q  <= '0;
      tmds_q <= INV_OUT ? ~TOK0 : TOK0;
    end else begin
      qm_q   <= qm_d;
      de1_q  <= de1_d;
      c1_q   <= c1_d;
`ifdef TMDS_TERC4_EN
      isl1_q <= isl1_d;
      aux1_q <= aux1_d;
`endif
      cnt_q  <= cnt_d;
      tmds_q <= tmds_d;
    end
  end

  assign disparity = cnt_q;

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// Scoreboard bench for tmds_encoder_8b10b: normal and INV_OUT=1 instances.
// Build with TMDS_TERC4_EN defined to exercise the data-island symbols.
module tb_tmds_encoder_8b10b;

  logic       pclk = 1'b0;
  logic       txrst = 1'b1;
  logic       de = 1'b0;
  logic [1:0] c = 2'b00;
  logic [7:0] din = 8'h00;
  logic       island = 1'b0;
  logic [3:0] aux = 4'h0;
  logic [9:0] tmds_q, tmds_inv;
  logic [4:0] disparity, disp_inv;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [9:0] t;
    logic [4:0] d;
  } exp_t;

  exp_t sb[$];

  tmds_encoder_8b10b #(.INV_OUT(1'b0)) dut (
    .pclk(pclk), .txrst(txrst), .de(de), .c(c), .din(din),
    .island(island), .aux(aux),
    .tmds_q(tmds_q), .disparity(disparity)
  );

  tmds_encoder_8b10b #(.INV_OUT(1'b1)) dut_inv (
    .pclk(pclk), .txrst(txrst), .de(de), .c(c), .din(din),
    .island(island), .aux(aux),
    .tmds_q(tmds_inv), .disparity(disp_inv)
  );

  always #5 pclk = ~pclk;

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  // monitor: compare whatever the scoreboard says is due after this edge
  initial forever begin
    exp_t e;
    @(posedge pclk);
    #1;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_symbol due=%0d now=%0d", e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      if (tmds_q !== e.t) begin
        failures++;
        $display("FAIL tmds cyc=%0d got=%h exp=%h", cyc, tmds_q, e.t);
      end
      checks++;
      if (disparity !== e.d) begin
        failures++;
        $display("FAIL disp cyc=%0d got=%h exp=%h", cyc, disparity, e.d);
      end
      checks++;
      if (tmds_inv !== (e.t ^ 10'h3FF)) begin
        failures++;
        $display("FAIL tmds_inv cyc=%0d got=%h exp=%h",
                 cyc, tmds_inv, e.t ^ 10'h3FF);
      end
      checks++;
      if (disp_inv !== e.d) begin
        failures++;
        $display("FAIL disp_inv cyc=%0d got=%h exp=%h", cyc, disp_inv, e.d);
      end
    end
  end

  task automatic drive(input logic r, input logic d, input logic [1:0] cc,
                       input logic [7:0] dd, input logic isl,
                       input logic [3:0] ax, input logic [9:0] et,
                       input logic [4:0] ed);
    exp_t e;
    @(negedge pclk);
    txrst = r;
    de = d;
    c = cc;
    din = dd;
    island = isl;
    aux = ax;
    if (r) begin
      // reset discards in-flight symbols; next two outputs are token 00
      while (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
      e.due = cyc + 1; e.t = 10'h354; e.d = 5'h00;
      sb.push_back(e);
      e.due = cyc + 2;
      sb.push_back(e);
    end else begin
      e.due = cyc + 2; e.t = et; e.d = ed;
      sb.push_back(e);
    end
  endtask

  localparam logic [9:0] X = 10'h354;

  initial begin
    repeat (3) drive(1, 0, 2'b00, 8'h00, 0, 4'h0, X, 5'h00);
    repeat (2) drive(0, 0, 2'b00, 8'h00, 0, 4'h0, 10'h354, 5'h00);
    drive(0, 0, 2'b01, 8'h00, 0, 4'h0, 10'h0AB, 5'h00);
    drive(0, 0, 2'b10, 8'h00, 0, 4'h0, 10'h154, 5'h00);
    drive(0, 0, 2'b11, 8'h00, 0, 4'h0, 10'h2AB, 5'h00);
    drive(0, 1, 2'b00, 8'h00, 0, 4'h0, 10'h100, 5'h18);
    drive(0, 1, 2'b00, 8'h00, 0, 4'h0, 10'h3FF, 5'h02);
    drive(0, 1, 2'b00, 8'h00, 0, 4'h0, 10'h100, 5'h1A);
    drive(0, 0, 2'b00, 8'h00, 0, 4'h0, 10'h354, 5'h00);
    drive(0, 1, 2'b11, 8'hFF, 1, 4'h5, 10'h200, 5'h18);
    drive(0, 0, 2'b00, 8'h00, 0, 4'h0, 10'h354, 5'h00);
    drive(0, 1, 2'b00, 8'h00, 0, 4'h0, 10'h100, 5'h18);
    drive(0, 1, 2'b00, 8'h0F, 0, 4'h0, 10'h3FA, 5'h1E);
    drive(0, 1, 2'b00, 8'h55, 0, 4'h0, 10'h133, 5'h1E);
    drive(0, 1, 2'b00, 8'hAA, 0, 4'h0, 10'h233, 5'h1E);
    drive(0, 1, 2'b00, 8'h01, 0, 4'h0, 10'h1FF, 5'h06);
    drive(0, 1, 2'b00, 8'h01, 0, 4'h0, 10'h300, 5'h00);
    drive(0, 1, 2'b00, 8'hFF, 0, 4'h0, 10'h200, 5'h18);
    drive(0, 1, 2'b00, 8'hFF, 0, 4'h0, 10'h0FF, 5'h1E);
    drive(0, 1, 2'b00, 8'hFF, 0, 4'h0, 10'h0FF, 5'h04);
    drive(0, 1, 2'b00, 8'hFF, 0, 4'h0, 10'h200, 5'h1C);
    drive(0, 1, 2'b00, 8'h00, 0, 4'h0, 10'h100, 5'h18);
    drive(1, 1, 2'b10, 8'h00, 0, 4'h0, X, 5'h00);
    drive(0, 0, 2'b00, 8'h00, 0, 4'h0, 10'h354, 5'h00);
    drive(0, 1, 2'b00, 8'h00, 0, 4'h0, 10'h100, 5'h18);
`ifdef TMDS_TERC4_EN
    drive(0, 0, 2'b00, 8'h00, 1, 4'h0, 10'h29C, 5'h00);
    drive(0, 0, 2'b01, 8'h00, 1, 4'hF, 10'h2C3, 5'h00);
    drive(0, 0, 2'b00, 8'h00, 1, 4'h6, 10'h18E, 5'h00);
`else
    drive(0, 0, 2'b00, 8'h00, 1, 4'h0, 10'h354, 5'h00);
    drive(0, 0, 2'b01, 8'h00, 1, 4'hF, 10'h0AB, 5'h00);
    drive(0, 0, 2'b00, 8'h00, 1, 4'h6, 10'h354, 5'h00);
`endif
    drive(0, 1, 2'b00, 8'h00, 1, 4'h3, 10'h100, 5'h18);
    repeat (2) drive(0, 0, 2'b00, 8'h00, 0, 4'h0, 10'h354, 5'h00);
    repeat (4) @(negedge pclk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
